// File: rtl/wf68k30l_multiplier.sv
// Core opcode/size constants and the MULU/MULS shift-add multiplier.
// One partial-product bit per clock on operand magnitudes; the sign is restored at the end.
package wf68k30l_pkg;
  localparam logic [6:0] MULS = 7'd52;
  localparam logic [6:0] MULU = 7'd53;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] WORD = 2'b01;
  localparam logic [1:0] LONG = 2'b10;
endpackage

module wf68k30l_multiplier
  import wf68k30l_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [6:0]  OP,
  input  logic [6:0]  OP_IN,
  input  logic [1:0]  OP_SIZE,
  input  logic        ALU_INIT,
  input  logic [15:0] BIW_1,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  output logic [31:0] PRODUCT_HI,
  output logic [31:0] PRODUCT_LO,
  output logic        VFLAG_MUL,
  output logic        MUL_RDY
);

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_INIT,
    MUL_CALC
  } t_mul_state;

  t_mul_state  r_state;
  t_mul_state  w_state_next;

  logic        r_neg,    w_neg_next;
  logic        r_signed, w_signed_next;
  logic        r_long,   w_long_next;
  logic        r_long64, w_long64_next;
  logic [5:0]  r_cnt,    w_cnt_next;
  logic [63:0] r_acc,    w_acc_next;
  logic [63:0] r_mcand,  w_mcand_next;
  logic [31:0] r_mplier, w_mplier_next;
  logic [31:0] r_prod_hi, w_prod_hi_next;
  logic [31:0] r_prod_lo, w_prod_lo_next;
  logic        r_vflag,  w_vflag_next;
  logic        r_rdy,    w_rdy_next;

  logic        w_is_signed;
  logic        w_is_long;
  logic [31:0] w_op1_ext;
  logic [31:0] w_op2_ext;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [63:0] w_acc_sum;
  logic [63:0] w_result;
  logic        w_vflag;
  logic        w_start;
  logic        w_unused;

  assign w_unused    = ^{BIW_1[15:11], BIW_1[9:0]};
  assign w_start     = ALU_INIT && ((OP_IN == MULS) || (OP_IN == MULU));
  assign w_is_signed = (OP == MULS);
  assign w_is_long   = (OP_SIZE == LONG);

  assign w_op1_ext = w_is_long   ? OP1 :
                     w_is_signed ? {{16{OP1[15]}}, OP1[15:0]} : {16'h0000, OP1[15:0]};
  assign w_op2_ext = w_is_long   ? OP2 :
                     w_is_signed ? {{16{OP2[15]}}, OP2[15:0]} : {16'h0000, OP2[15:0]};

  // 32'h8000_0000 negates to itself, which read unsigned is exactly 2^31.
  assign w_op1_mag = (w_is_signed && w_op1_ext[31]) ? (~w_op1_ext + 32'd1) : w_op1_ext;
  assign w_op2_mag = (w_is_signed && w_op2_ext[31]) ? (~w_op2_ext + 32'd1) : w_op2_ext;

  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : 64'h0);
  assign w_result  = r_neg ? (~w_acc_sum + 64'd1) : w_acc_sum;

  // Only the 32-bit long form can overflow; the result must fit Dl alone.
  assign w_vflag = r_long && !r_long64 &&
                   (r_signed ? (w_result[63:32] != {32{w_result[31]}})
                             : (w_result[63:32] != 32'h0));

  always_comb begin
    w_state_next   = r_state;
    w_neg_next     = r_neg;
    w_signed_next  = r_signed;
    w_long_next    = r_long;
    w_long64_next  = r_long64;
    w_cnt_next     = r_cnt;
    w_acc_next     = r_acc;
    w_mcand_next   = r_mcand;
    w_mplier_next  = r_mplier;
    w_prod_hi_next = r_prod_hi;
    w_prod_lo_next = r_prod_lo;
    w_vflag_next   = r_vflag;
    w_rdy_next     = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if (w_start) begin
          w_state_next = MUL_INIT;
        end
      end
      MUL_INIT: begin
        w_signed_next = w_is_signed;
        w_long_next   = w_is_long;
        w_long64_next = BIW_1[10];
        w_neg_next    = w_is_signed && (w_op1_ext[31] ^ w_op2_ext[31]);
        if ((w_op1_mag == 32'h0) || (w_op2_mag == 32'h0)) begin
          w_prod_hi_next = 32'h0;
          w_prod_lo_next = 32'h0;
          w_vflag_next   = 1'b0;
          w_rdy_next     = 1'b1;
          w_state_next   = MUL_IDLE;
        end else begin
          w_cnt_next    = w_is_long ? 6'd32 : 6'd16;
          w_acc_next    = 64'h0;
          w_mcand_next  = {32'h0, w_op2_mag};
          w_mplier_next = w_op1_mag;
          w_state_next  = MUL_CALC;
        end
      end
      MUL_CALC: begin
        w_acc_next    = w_acc_sum;
        w_mcand_next  = {r_mcand[62:0], 1'b0};
        w_mplier_next = {1'b0, r_mplier[31:1]};
        w_cnt_next    = r_cnt - 6'd1;
        if (r_cnt == 6'd1) begin
          w_prod_hi_next = w_result[63:32];
          w_prod_lo_next = w_result[31:0];
          w_vflag_next   = w_vflag;
          w_rdy_next     = 1'b1;
          w_state_next   = MUL_IDLE;
        end
      end
      default: begin
        w_state_next = MUL_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state   <= MUL_IDLE;
      r_neg     <= 1'b0;
      r_signed  <= 1'b0;
      r_long    <= 1'b0;
      r_long64  <= 1'b0;
      r_cnt     <= 6'd0;
      r_acc     <= 64'h0;
      r_mcand   <= 64'h0;
      r_mplier  <= 32'h0;
      r_prod_hi <= 32'h0;
      r_prod_lo <= 32'h0;
      r_vflag   <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_neg     <= w_neg_next;
      r_signed  <= w_signed_next;
      r_long    <= w_long_next;
      r_long64  <= w_long64_next;
      r_cnt     <= w_cnt_next;
      r_acc     <= w_acc_next;
      r_mcand   <= w_mcand_next;
      r_mplier  <= w_mplier_next;
      r_prod_hi <= w_prod_hi_next;
      r_prod_lo <= w_prod_lo_next;
      r_vflag   <= w_vflag_next;
      r_rdy     <= w_rdy_next;
    end
  end

  assign PRODUCT_HI = r_prod_hi;
  assign PRODUCT_LO = r_prod_lo;
  assign VFLAG_MUL  = r_vflag;
  assign MUL_RDY    = r_rdy;

endmodule
